// File: rtl/ledger_port_arbiter.sv
// ledger_port_arbiter: single RAM port shared by display fetch (disp_*), pixel RMW writer (wr_*) and clear engine (clr_*), driving ram_*
module ledger_port_arbiter #(
  parameter int ROWS = 480,
  parameter int COLS = 80,
  parameter int ADDR_W = 16
)(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [31:0]       disp_data,
  output logic              disp_valid,
  input  logic              wr_req,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [3:0]        wr_gray,
  output logic              wr_done,
  output logic              wr_err,
  input  logic              clr_req,
  input  logic [31:0]       clr_word,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, WAIT = 3'd2, WR = 3'd3, CLR = 3'd4;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS * COLS - 1);
  logic [2:0] state;
  logic [ADDR_W-1:0] addr, cnt;
  logic [2:0] sel;
  logic [3:0] gray;
  logic [31:0] merged, fill, merge_w;
  logic drop_done;
  assign wr_ready = Reset_n && state == IDLE && !clr_req;
  assign ram_addr = disp_req ? disp_addr : (state == CLR ? cnt : addr);
  assign ram_we = Reset_n && !disp_req && (state == WR || state == CLR);
  assign ram_wdata = state == CLR ? fill : merged;
  assign disp_data = ram_rdata;
  assign wr_done = drop_done || (Reset_n && !disp_req && state == WR);
  always_comb begin
    merge_w = ram_rdata;
    merge_w[{sel, 2'b00} +: 4] = gray;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt <= '0;
      disp_valid <= 1'b0;
      drop_done <= 1'b0;
      wr_err <= 1'b0;
      clr_done <= 1'b0;
      clr_busy <= 1'b0;
    end else begin
      disp_valid <= disp_req;
      drop_done <= 1'b0;
      wr_err <= 1'b0;
      clr_done <= 1'b0;
      case (state)
        IDLE:
          if (clr_req) begin
            fill <= clr_word;
            cnt <= '0;
            clr_busy <= 1'b1;
            state <= CLR;
          end else if (wr_req) begin
            gray <= wr_gray;
            sel <= 3'd7 - wr_x[2:0];
            addr <= (ADDR_W'(wr_y) << 6) + (ADDR_W'(wr_y) << 4) + ADDR_W'(wr_x[9:3]);
            if (wr_x >= 10'(COLS * 8) || wr_y >= 10'(ROWS)) begin
              drop_done <= 1'b1;
              wr_err <= 1'b1;
            end else state <= RD;
          end
        RD: state <= disp_req ? RD : WAIT;
        WAIT: begin
          merged <= merge_w;
          state <= WR;
        end
        WR: state <= disp_req ? WR : IDLE;
        CLR:
          if (!disp_req) begin
            if (cnt == LAST) begin
              clr_done <= 1'b1;
              clr_busy <= 1'b0;
              state <= IDLE;
            end else cnt <= cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ledger_port_arbiter.sv
// tb_ledger_port_arbiter: directed bench for ledger_port_arbiter with a behavioural single-port RAM
module tb_ledger_port_arbiter;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic disp_req = 1'b0;
  logic [15:0] disp_addr = '0;
  logic [31:0] disp_data;
  logic disp_valid;
  logic wr_req = 1'b0;
  logic wr_ready;
  logic [9:0] wr_x = '0, wr_y = '0;
  logic [3:0] wr_gray = '0;
  logic wr_done, wr_err;
  logic clr_req = 1'b0;
  logic [31:0] clr_word = '0;
  logic clr_busy, clr_done;
  logic [15:0] ram_addr;
  logic ram_we;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] mem [0:38399];
  logic bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  int checks = 0;
  int errors = 0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end
  ledger_port_arbiter #(.ROWS(480), .COLS(80), .ADDR_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_req(wr_req), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_gray(wr_gray),
    .wr_done(wr_done), .wr_err(wr_err),
    .clr_req(clr_req), .clr_word(clr_word), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  task automatic bd_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge Clk);
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(negedge Clk);
    bd_we = 1'b0;
  endtask
  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    checks++;
    if ({disp_valid, wr_done, wr_err, clr_done, clr_busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {disp_valid, wr_done, wr_err, clr_done, clr_busy});
    end
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0", wr_ready);
    end
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_we: got %b expected 0", ram_we);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    #1;
    checks++;
    if ({wr_ready, ram_we, clr_busy, wr_done} !== 4'b1000) begin
      errors++;
      $display("FAIL release_idle: got %b expected 1000", {wr_ready, ram_we, clr_busy, wr_done});
    end
  endtask
  task automatic test_rmw;
    bd_write(16'd160, 32'h12345678);
    @(negedge Clk);
    wr_req = 1'b1;
    wr_x = 10'd5;
    wr_y = 10'd2;
    wr_gray = 4'hA;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmw_ready: got %b expected 1", wr_ready);
    end
    @(negedge Clk);
    wr_req = 1'b0;
    #1;
    checks++;
    if ({ram_we, ram_addr} !== {1'b0, 16'd160}) begin
      errors++;
      $display("FAIL rmw_read: got we=%b addr=%0d expected we=0 addr=160", ram_we, ram_addr);
    end
    @(negedge Clk);
    #1;
    checks++;
    if ({ram_we, wr_done} !== 2'b00) begin
      errors++;
      $display("FAIL rmw_wait: got we=%b done=%b expected 0 0", ram_we, wr_done);
    end
    @(negedge Clk);
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_wdata, wr_done, wr_err} !== {1'b1, 16'd160, 32'h12345A78, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rmw_write: got we=%b addr=%0d data=%h done=%b err=%b expected 1 160 12345a78 1 0",
               ram_we, ram_addr, ram_wdata, wr_done, wr_err);
    end
    @(negedge Clk);
    #1;
    checks++;
    if ({mem[160], wr_done, wr_ready} !== {32'h12345A78, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rmw_after: got mem=%h done=%b ready=%b expected 12345a78 0 1", mem[160], wr_done, wr_ready);
    end
  endtask
  task automatic test_contention;
    logic [31:0] exp_d;
    bd_write(16'd160, 32'h12345678);
    bd_write(16'd10, 32'hA0A0A0A0);
    bd_write(16'd11, 32'hB1B1B1B1);
    bd_write(16'd12, 32'hC2C2C2C2);
    @(negedge Clk);
    wr_req = 1'b1;
    wr_x = 10'd5;
    wr_y = 10'd2;
    wr_gray = 4'hA;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      wr_req = 1'b0;
      disp_req = c <= 3;
      disp_addr = 16'(9 + c);
      #1;
      if (c <= 3) begin
        checks++;
        if ({ram_we, ram_addr} !== {1'b0, 16'(9 + c)}) begin
          errors++;
          $display("FAIL cont_prio c=%0d: got we=%b addr=%0d expected 0 %0d", c, ram_we, ram_addr, 9 + c);
        end
      end
      if (c >= 2 && c <= 4) begin
        exp_d = c == 2 ? 32'hA0A0A0A0 : c == 3 ? 32'hB1B1B1B1 : 32'hC2C2C2C2;
        checks++;
        if ({disp_valid, disp_data} !== {1'b1, exp_d}) begin
          errors++;
          $display("FAIL cont_disp c=%0d: got v=%b d=%h expected 1 %h", c, disp_valid, disp_data, exp_d);
        end
      end
      if (c == 5) begin
        checks++;
        if ({disp_valid, ram_we} !== 2'b00) begin
          errors++;
          $display("FAIL cont_wait: got v=%b we=%b expected 0 0", disp_valid, ram_we);
        end
      end
      if (c < 6) begin
        checks++;
        if (wr_done !== 1'b0) begin
          errors++;
          $display("FAIL cont_early_done c=%0d: got %b expected 0", c, wr_done);
        end
      end else begin
        checks++;
        if ({ram_we, ram_addr, ram_wdata, wr_done, wr_err} !== {1'b1, 16'd160, 32'h12345A78, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL cont_write: got we=%b addr=%0d data=%h done=%b err=%b expected 1 160 12345a78 1 0",
                   ram_we, ram_addr, ram_wdata, wr_done, wr_err);
        end
      end
    end
    @(negedge Clk);
    disp_req = 1'b0;
    #1;
    checks++;
    if (mem[160] !== 32'h12345A78) begin
      errors++;
      $display("FAIL cont_mem: got %h expected 12345a78", mem[160]);
    end
  endtask
  task automatic test_drop;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      wr_req = 1'b1;
      wr_x = i == 0 ? 10'd640 : 10'd0;
      wr_y = i == 0 ? 10'd0 : 10'd480;
      wr_gray = 4'h3;
      @(negedge Clk);
      wr_req = 1'b0;
      #1;
      checks++;
      if ({wr_done, wr_err, ram_we, wr_ready} !== 4'b1101) begin
        errors++;
        $display("FAIL drop_%0d: got done/err/we/ready=%b expected 1101", i, {wr_done, wr_err, ram_we, wr_ready});
      end
      @(negedge Clk);
      #1;
      checks++;
      if ({wr_done, wr_err, ram_we} !== 3'b000) begin
        errors++;
        $display("FAIL drop_%0d_after: got %b expected 000", i, {wr_done, wr_err, ram_we});
      end
    end
  endtask
  task automatic test_clear;
    int nw = 0, done_cnt = 0, done_at = 0, bad_ready = 0, bad_wr = 0, bad_dv = 0, bad_busy = 0, bad_mem = 0;
    logic prev;
    @(negedge Clk);
    clr_req = 1'b1;
    clr_word = 32'hFFFFFFFF;
    wr_req = 1'b1;
    wr_x = 10'd0;
    wr_y = 10'd0;
    wr_gray = 4'h5;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_prio_ready: got %b expected 0", wr_ready);
    end
    for (int k = 1; k <= 50000; k++) begin
      @(negedge Clk);
      clr_req = 1'b0;
      wr_req = 1'b0;
      prev = disp_req;
      disp_req = k % 8 == 0;
      disp_addr = 16'(k % 38400);
      #1;
      if (ram_we === 1'b1) nw++;
      if (done_cnt == 0 && clr_done !== 1'b1 && wr_ready !== 1'b0) bad_ready++;
      if (done_cnt == 0 && clr_done !== 1'b1 && clr_busy !== 1'b1) bad_busy++;
      if (wr_done !== 1'b0) bad_wr++;
      if (disp_valid !== prev) bad_dv++;
      if (clr_done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (done_cnt > 0 && k >= done_at + 2) break;
    end
    disp_req = 1'b0;
    checks++;
    if (done_cnt != 1 || done_at != 43886) begin
      errors++;
      $display("FAIL clr_done: got pulses=%0d at=%0d expected 1 at 43886", done_cnt, done_at);
    end
    checks++;
    if (nw != 38400) begin
      errors++;
      $display("FAIL clr_writes: got %0d expected 38400", nw);
    end
    checks++;
    if (bad_ready != 0 || bad_busy != 0) begin
      errors++;
      $display("FAIL clr_ready_busy: got bad_ready=%0d bad_busy=%0d expected 0 0", bad_ready, bad_busy);
    end
    checks++;
    if (bad_wr != 0 || bad_dv != 0) begin
      errors++;
      $display("FAIL clr_wr_disp: got bad_wr=%0d bad_dv=%0d expected 0 0", bad_wr, bad_dv);
    end
    for (int a = 0; a < 38400; a++) if (mem[a] !== 32'hFFFFFFFF) bad_mem++;
    checks++;
    if (bad_mem != 0 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_mem: got bad_words=%0d busy=%b expected 0 0", bad_mem, clr_busy);
    end
  endtask
  task automatic test_reset_mid_clear;
    int bad_lo = 0, bad_hi = 0, bad_we = 0;
    @(negedge Clk);
    clr_req = 1'b1;
    clr_word = 32'h00000000;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge Clk);
      clr_req = 1'b0;
    end
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({ram_addr, ram_we} !== {16'd1000, 1'b0}) begin
      errors++;
      $display("FAIL rst_clr_cut: got addr=%0d we=%b expected 1000 0", ram_addr, ram_we);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      #1;
      if (ram_we !== 1'b0) bad_we++;
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    #1;
    if (ram_we !== 1'b0) bad_we++;
    checks++;
    if (bad_we != 0 || {clr_busy, clr_done, wr_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rst_clr_state: got bad_we=%0d busy/done/ready=%b expected 0 001", bad_we, {clr_busy, clr_done, wr_ready});
    end
    for (int a = 0; a < 38400; a++) begin
      if (a < 1000 && mem[a] !== 32'h0) bad_lo++;
      if (a >= 1000 && mem[a] !== 32'hFFFFFFFF) bad_hi++;
    end
    checks++;
    if (bad_lo != 0 || bad_hi != 0) begin
      errors++;
      $display("FAIL rst_clr_mem: got bad_lo=%0d bad_hi=%0d expected 0 0", bad_lo, bad_hi);
    end
  endtask
  initial begin
    test_reset;
    test_rmw;
    test_contention;
    test_drop;
    test_clear;
    test_reset_mid_clear;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
